reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//  Architectural register file: receives writeback (RdW/ResultW/RegWriteW) and serves decode.
//  Two combinational read ports with same-cycle write bypass. One synchronous write port.
//  Per-register pending-write counters (scoreboard) raise StallD when decode reads a register
//  that an in-flight instruction has not yet written back.
//  Sits between decodeStage (reads, issue) and writeBackStage (writes); feeds the hazard unit.
// PARAMETERS
//  NREG    32           number of architectural registers; x0 hardwired to zero
//  AW      5            register address width, = clog2(NREG)
//  CNT_W   2            pending counter width; max in-flight writers per reg = 2**CNT_W-1 (3)
//  data width is `WORD_SIZE from constants.v (not a parameter)
// PORTS
//  clk         in   1     clock; all state updates on posedge
//  rst         in   1     asynchronous, active-high reset
//  A1D, A2D    in   AW    rs1/rs2 read addresses from decode
//  Use1D,Use2D in   1     decode instruction actually reads rs1/rs2
//  RD1D, RD2D  out  WORD  read data (combinational)
//  IssueD      in   1     decode instr leaves D this cycle and will write RdIssueD
//  RdIssueD    in   AW    destination of issuing instr
//  FlushE      in   1     instr in E is squashed; it counted on RdE
//  RegWriteE   in   1     squashed instr had been counted (writes a register)
//  RdE         in   AW    destination of squashed instr
//  RegWriteW   in   1     writeback enable
//  RdW         in   AW    writeback destination
//  ResultW     in   WORD  writeback data
//  StallD      out  1     decode must hold (combinational)
//  ScoreErrH   out  1     sticky: counter underflow/overflow detected
// BEHAVIOUR
//  Reset (async, any time incl. mid-operation): all regs := 0, all counters := 0,
//   ScoreErrH := 0; RD1D/RD2D therefore read 0, StallD := 0.
//  Write: posedge, if RegWriteW && RdW!=0 -> reg[RdW] := ResultW. Writes to x0 dropped.
//  Read: RDn = 0 if An==0; else ResultW if RegWriteW && RdW==An; else reg[An]. Zero latency.
//  wb_hit(a) = RegWriteW && RdW==a && a!=0.
//  Stall terms: hazN = UseND && AN!=0 && pend[AN] > (wb_hit(AN) ? 1 : 0);
//   full = IssueD && RdIssueD!=0 && pend[RdIssueD]==max && !wb_hit(RdIssueD);
//   StallD = haz1 | haz2 | full.
//  Counter update per reg r (posedge), net of three events, all applied in one cycle:
//   +1 if IssueD && !StallD && RdIssueD==r; -1 if wb_hit(r);
//   -1 if FlushE && RegWriteE && RdE==r. x0 counter stays 0 always.
//  Simultaneous issue+writeback to same reg: net 0. Issue gated by StallD (stalled issue not counted).
//  Underflow (net result <0) -> counter := 0, ScoreErrH := 1.
//  Overflow (net >max, only reachable if caller ignores StallD) -> saturate, ScoreErrH := 1.
//  ScoreErrH is sticky until rst.
//  Under $display debug, print register writes after #5 on posedge like other stages.
// STRUCTURE
//  constants.v: add `REG_ADDR_SIZE (5), `NUM_REGS (32), `SB_CNT_SIZE (2); no new typedefs.
//  Sub-module: sb_counter (one CNT_W up/down counter w/ inc, dec0, dec1, sat, err); generate x NREG-1.
//  Storage: reg array with async-reset loop; read/bypass muxes combinational in top.
// TESTING
//  1 rst mid-run after writes -> RD1D(A1D=5)=0, StallD=0, ScoreErrH=0 same cycle, no clk edge.
//  2 RegWriteW=1,RdW=7,ResultW=0xDEADBEEF, A1D=7 same cycle -> RD1D=0xDEADBEEF;
//    next cycle reg[7] holds it; RdW=0 write -> RD(x0)=0.
//  3 Issue RdIssueD=3; next cycle Use1D,A1D=3 -> StallD=1; writeback x3 arrives ->
//    StallD=0 that cycle, RD1D=ResultW.
//  4 Issue to x9 three times (no wb), 4th issue to x9 -> StallD=1 (full), count stays 3; one wb
//    x9 same cycle as 4th issue -> StallD=0, count stays 3.
//  5 Issue x4 then FlushE,RegWriteE,RdE=4 -> pend[4]=0, Use1D A1D=4 no stall;
//    extra wb to x4 -> ScoreErrH=1, pend stays 0.
//  6 Same-cycle issue x6 + wb x6 (pend was 1) -> pend[6]=1, no stall on the issue.

Source files
------------

// File: rtl/reg_file_scoreboard_pkg.sv
// rtl/reg_file_scoreboard_pkg.sv - shared sizes for the register file and its scoreboard
package reg_file_scoreboard_pkg;
    localparam int WORD_SIZE     = 32;
    localparam int NUM_REGS      = 32;
    localparam int REG_ADDR_SIZE = 5;
    localparam int SB_CNT_SIZE   = 2;
    localparam int SB_CNT_MAX    = (1 << SB_CNT_SIZE) - 1;

    typedef logic [WORD_SIZE-1:0] word_t;
endpackage

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - one pending-write counter: +inc -dec0 -dec1 per cycle, clamped, sticky err
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec0,
    input  logic             dec1,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             err
);
    // Two guard bits: top bit flags a negative net, next bit flags overflow past max.
    logic [CNT_W+1:0] net;

    always_comb begin
        net = {2'b00, count}
            + {{(CNT_W+1){1'b0}}, inc}
            - {{(CNT_W+1){1'b0}}, dec0}
            - {{(CNT_W+1){1'b0}}, dec1};
    end

    assign sat = (count == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            err   <= 1'b0;
        end else if (net[CNT_W+1]) begin
            count <= '0;
            err   <= 1'b1;
        end else if (net[CNT_W]) begin
            count <= {CNT_W{1'b1}};
            err   <= 1'b1;
        end else begin
            count <= net[CNT_W-1:0];
        end
    end
endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with write bypass and per-register pending-write stall
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int NREG  = NUM_REGS,
    parameter int AW    = REG_ADDR_SIZE,
    parameter int CNT_W = SB_CNT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW-1:0]        A1D,
    input  logic [AW-1:0]        A2D,
    input  logic                 Use1D,
    input  logic                 Use2D,
    output logic [WORD_SIZE-1:0] RD1D,
    output logic [WORD_SIZE-1:0] RD2D,
    input  logic                 IssueD,
    input  logic [AW-1:0]        RdIssueD,
    input  logic                 FlushE,
    input  logic                 RegWriteE,
    input  logic [AW-1:0]        RdE,
    input  logic                 RegWriteW,
    input  logic [AW-1:0]        RdW,
    input  logic [WORD_SIZE-1:0] ResultW,
    output logic                 StallD,
    output logic                 ScoreErrH
);
    logic [WORD_SIZE-1:0] regs [NREG];
    logic [CNT_W-1:0]     pend [NREG];
    logic [NREG-1:0]      errVec;
    logic [NREG-1:0]      satVec;
    logic                 wbHit1, wbHit2, wbHitI;
    logic                 haz1, haz2, full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (RegWriteW && RdW != '0) begin
            regs[RdW] <= ResultW;
        end
    end

    assign RD1D = (A1D == '0) ? '0 : (RegWriteW && RdW == A1D) ? ResultW : regs[A1D];
    assign RD2D = (A2D == '0) ? '0 : (RegWriteW && RdW == A2D) ? ResultW : regs[A2D];

    assign wbHit1 = RegWriteW && RdW == A1D && A1D != '0;
    assign wbHit2 = RegWriteW && RdW == A2D && A2D != '0;
    assign wbHitI = RegWriteW && RdW == RdIssueD && RdIssueD != '0;

    // A writeback landing this cycle retires one pending writer, so it may be the last one.
    assign haz1 = Use1D && A1D != '0 && pend[A1D] > CNT_W'(wbHit1);
    assign haz2 = Use2D && A2D != '0 && pend[A2D] > CNT_W'(wbHit2);
    assign full = IssueD && RdIssueD != '0 && satVec[RdIssueD] && !wbHitI;

    assign StallD = haz1 | haz2 | full;

    assign pend[0]   = '0;
    assign errVec[0] = 1'b0;
    assign satVec[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : gCnt
        sb_counter #(.CNT_W(CNT_W)) uCnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (IssueD && !StallD && RdIssueD == AW'(g)),
            .dec0  (RegWriteW && RdW == AW'(g)),
            .dec1  (FlushE && RegWriteE && RdE == AW'(g)),
            .count (pend[g]),
            .sat   (satVec[g]),
            .err   (errVec[g])
        );
    end

    assign ScoreErrH = |errVec;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - scoreboard bench: directed hazard cases plus randomized traffic
module tb_reg_file_scoreboard;
    import reg_file_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1D, A2D, RdIssueD, RdE, RdW;
    logic        Use1D, Use2D, IssueD, FlushE, RegWriteE, RegWriteW;
    logic [31:0] ResultW, RD1D, RD2D;
    logic        StallD, ScoreErrH;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk(clk), .rst(rst), .A1D(A1D), .A2D(A2D), .Use1D(Use1D), .Use2D(Use2D),
        .RD1D(RD1D), .RD2D(RD2D), .IssueD(IssueD), .RdIssueD(RdIssueD),
        .FlushE(FlushE), .RegWriteE(RegWriteE), .RdE(RdE), .RegWriteW(RegWriteW),
        .RdW(RdW), .ResultW(ResultW), .StallD(StallD), .ScoreErrH(ScoreErrH)
    );

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mReg[32];
    int          mPend[32];
    bit          mErr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit wb(input logic [4:0] a);
        return RegWriteW && RdW == a && a != 0;
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (RegWriteW && RdW == a) return ResultW;
        return mReg[a];
    endfunction

    function automatic exp_t modelOut();
        exp_t e;
        bit   h1, h2, f;
        e.rd1 = readModel(A1D);
        e.rd2 = readModel(A2D);
        h1 = Use1D && A1D != 0 && mPend[A1D] > (wb(A1D) ? 1 : 0);
        h2 = Use2D && A2D != 0 && mPend[A2D] > (wb(A2D) ? 1 : 0);
        f  = IssueD && RdIssueD != 0 && mPend[RdIssueD] == SB_CNT_MAX && !wb(RdIssueD);
        e.stall = h1 | h2 | f;
        e.err   = mErr;
        return e;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            mReg[r]  = 32'h0;
            mPend[r] = 0;
        end
        mErr = 1'b0;
    endtask

    task automatic modelCommit(input bit stall);
        int net;
        for (int r = 1; r < 32; r++) begin
            net = mPend[r];
            if (IssueD && !stall && RdIssueD == r) net++;
            if (wb(5'(r))) net--;
            if (FlushE && RegWriteE && RdE == r) net--;
            if (net < 0) begin
                net  = 0;
                mErr = 1'b1;
            end else if (net > SB_CNT_MAX) begin
                net  = SB_CNT_MAX;
                mErr = 1'b1;
            end
            mPend[r] = net;
        end
        if (RegWriteW && RdW != 0) mReg[RdW] = ResultW;
    endtask

    task automatic idle();
        A1D = 0; A2D = 0; Use1D = 0; Use2D = 0; IssueD = 0; RdIssueD = 0;
        FlushE = 0; RegWriteE = 0; RdE = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step();
        exp_t e;
        e = modelOut();
        expQ.push_back(e);
        @(posedge clk);
        modelCommit(e.stall);
        #1;
        idle();
    endtask

    task automatic midReset(input string tag);
        rst = 1'b1;
        A1D = 5; Use1D = 1'b1;
        #1;
        chk({tag, "_rd1"}, RD1D, 32'h0);
        chk({tag, "_stall"}, {31'h0, StallD}, 32'h0);
        chk({tag, "_err"}, {31'h0, ScoreErrH}, 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk("rd1", RD1D, e.rd1);
            chk("rd2", RD2D, e.rd2);
            chk("stall", {31'h0, StallD}, {31'h0, e.stall});
            chk("err", {31'h0, ScoreErrH}, {31'h0, e.err});
        end
    end

    initial begin
        int pendList[$];
        idle();
        modelReset();
        rst = 1'b1;
        #2;
        midReset("reset0");

        // bypass then stored value, then x0 write dropped
        RegWriteW = 1; RdW = 7; ResultW = 32'hDEADBEEF; A1D = 7; step();
        A1D = 7; A2D = 7; step();
        RegWriteW = 1; RdW = 0; ResultW = 32'h1234; A1D = 0; A2D = 0; step();

        // RAW hazard resolved by same-cycle writeback
        IssueD = 1; RdIssueD = 3; step();
        Use1D = 1; A1D = 3; step();
        Use1D = 1; A1D = 3; RegWriteW = 1; RdW = 3; ResultW = 32'hA5A5_0003; step();

        // counter full on x9, then writeback makes room in the same cycle
        repeat (3) begin IssueD = 1; RdIssueD = 9; step(); end
        IssueD = 1; RdIssueD = 9; step();
        IssueD = 1; RdIssueD = 9; RegWriteW = 1; RdW = 9; ResultW = 32'h9; step();
        Use2D = 1; A2D = 9; step();
        repeat (3) begin RegWriteW = 1; RdW = 9; ResultW = 32'h99; step(); end
        Use2D = 1; A2D = 9; step();

        // flush cancels, extra writeback underflows
        IssueD = 1; RdIssueD = 4; step();
        FlushE = 1; RegWriteE = 1; RdE = 4; step();
        Use1D = 1; A1D = 4; step();
        RegWriteW = 1; RdW = 4; ResultW = 32'h44; step();
        Use1D = 1; A1D = 4; step();
        step();

        // same-cycle issue and writeback on x6
        IssueD = 1; RdIssueD = 6; step();
        IssueD = 1; RdIssueD = 6; RegWriteW = 1; RdW = 6; ResultW = 32'h66; step();
        Use1D = 1; A1D = 6; step();
        RegWriteW = 1; RdW = 6; ResultW = 32'h67; step();
        Use1D = 1; A1D = 6; A2D = 7; step();

        midReset("reset1");

        for (int c = 0; c < 600; c++) begin
            if (c % 150 == 149) midReset("resetR");
            A1D = 5'($urandom_range(0, 7));
            A2D = 5'($urandom_range(0, 7));
            Use1D = ($urandom_range(0, 1) == 1);
            Use2D = ($urandom_range(0, 1) == 1);
            IssueD = ($urandom_range(0, 9) < 4);
            RdIssueD = 5'($urandom_range(0, 7));
            ResultW = $urandom;
            pendList.delete();
            for (int r = 1; r < 8; r++) if (mPend[r] > 0) pendList.push_back(r);
            if (pendList.size() > 0 && $urandom_range(0, 1) == 1) begin
                RegWriteW = 1;
                RdW = 5'(pendList[$urandom_range(0, pendList.size() - 1)]);
            end else if ($urandom_range(0, 19) == 0) begin
                RegWriteW = 1;
                RdW = 5'($urandom_range(0, 7));
            end
            if (pendList.size() > 0 && $urandom_range(0, 9) == 0) begin
                FlushE = 1;
                RegWriteE = ($urandom_range(0, 3) != 0);
                RdE = 5'(pendList[$urandom_range(0, pendList.size() - 1)]);
            end
            step();
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", expQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
